// File: rtl/pipeline_pkg.sv
// Shared types for the fetch front end: the {pc, instr} entry format and the
// instruction stride.
package pipeline_pkg;
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  localparam int INSTR_BYTES = 4;

  // Redirect targets are word addresses; the low two bits are dropped.
  function automatic logic [31:0] align_pc(input logic [31:0] pc);
    return {pc[31:2], 2'b00};
  endfunction
endpackage

// File: rtl/fetch_queue_if.sv
// Fetch front-end bundle: instruction memory port, redirect request and the
// decode-side valid/ready handshake. master = fetch_queue, slave = its peers.
interface fetch_queue_if #(
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH + 1);

  logic [31:0]   imem_addr;
  logic [31:0]   imem_rdata;
  logic          redirect_valid;
  logic [31:0]   redirect_pc;
  logic          out_valid;
  logic          out_ready;
  logic [31:0]   out_pc;
  logic [31:0]   out_instr;
  logic [CW-1:0] count;

  modport master (
    output imem_addr, out_valid, out_pc, out_instr, count,
    input  imem_rdata, redirect_valid, redirect_pc, out_ready
  );

  modport slave (
    input  imem_addr, out_valid, out_pc, out_instr, count,
    output imem_rdata, redirect_valid, redirect_pc, out_ready
  );
endinterface

// File: rtl/sync_fifo.sv
// Registered FIFO with a synchronous flush. The head is read straight from
// storage, so a same-cycle push into the slot being popped is safe when full.
module sync_fifo #(
  parameter  int WIDTH = 64,
  parameter  int DEPTH = 4,
  localparam int CW    = $clog2(DEPTH + 1),
  localparam int PW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic [CW-1:0]    count
);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]    count_q, count_d;

  always_comb begin
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = wdata;
        wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
      if (push && !pop)      count_d = count_q + 1'b1;
      else if (pop && !push) count_d = count_q - 1'b1;
    end
  end

  // Storage is cleared on reset so the head reads as zero out of reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  assign rdata = mem_q[rd_ptr_q];
  assign count = count_q;
endmodule

// File: rtl/fetch_queue.sv
// Instruction-fetch front end: owns the fetch PC, captures {pc, instr} into a
// prefetch queue and hands the head to decode; a redirect flushes everything.
module fetch_queue
  import pipeline_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input logic           clk,
  input logic           rst,
  fetch_queue_if.master fq
);
  localparam int CW = $clog2(DEPTH + 1);

  logic [31:0]  pc_q, pc_d;
  logic         push, pop;
  logic [CW-1:0] cnt;
  fetch_entry_t wr_entry, head;

  assign fq.out_valid = (cnt != '0);

  // Redirect wins over everything: no push, and decode's ready is ignored.
  assign pop  = fq.out_valid & fq.out_ready & ~fq.redirect_valid;
  assign push = ~fq.redirect_valid & ((cnt < CW'(DEPTH)) | pop);

  always_comb begin
    pc_d = pc_q;
    if (fq.redirect_valid) pc_d = align_pc(fq.redirect_pc);
    else if (push)         pc_d = pc_q + 32'(INSTR_BYTES);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) pc_q <= RESET_PC;
    else      pc_q <= pc_d;
  end

  assign wr_entry = '{pc: pc_q, instr: fq.imem_rdata};

  sync_fifo #(
    .WIDTH ($bits(fetch_entry_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (fq.redirect_valid),
    .push  (push),
    .pop   (pop),
    .wdata (wr_entry),
    .rdata (head),
    .count (cnt)
  );

  assign fq.imem_addr = pc_q;
  assign fq.out_pc    = head.pc;
  assign fq.out_instr = head.instr;
  assign fq.count     = cnt;
endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: a scoreboard of expected {pc, instr} entries
// is filled as fetches are predicted and compared against the queue head.
module tb_fetch_queue;
  import pipeline_pkg::*;

  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst;
  int   tests = 0;
  int   fails = 0;

  logic [63:0] sb[$];
  logic [31:0] mpc;

  fetch_queue_if #(.DEPTH(DEPTH)) fq ();

  fetch_queue #(
    .DEPTH    (DEPTH),
    .RESET_PC (32'h0000_0000)
  ) dut (
    .clk (clk),
    .rst (rst),
    .fq  (fq)
  );

  always #5 clk = ~clk;

  // Combinational instruction memory: word at addr is 0x1000_0000 | addr.
  assign fq.imem_rdata = 32'h1000_0000 | fq.imem_addr;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_state(input string tag);
    chk({tag, "_valid"}, 64'(fq.out_valid), 64'(sb.size() != 0));
    chk({tag, "_count"}, 64'(fq.count), 64'(sb.size()));
    chk({tag, "_addr"}, 64'(fq.imem_addr), 64'(mpc));
    if (sb.size() != 0) chk({tag, "_head"}, {fq.out_pc, fq.out_instr}, sb[0]);
  endtask

  // Check at the falling edge, drive, predict, cross one rising edge.
  task automatic step(input logic rdy, input logic rv, input logic [31:0] rpc, input string tag);
    bit do_pop, do_push;
    chk_state(tag);
    fq.out_ready      = rdy;
    fq.redirect_valid = rv;
    fq.redirect_pc    = rpc;
    do_pop  = (sb.size() != 0) && rdy && !rv;
    do_push = !rv && ((sb.size() < DEPTH) || do_pop);
    @(posedge clk);
    if (rv) begin
      sb.delete();
      mpc = {rpc[31:2], 2'b00};
    end else begin
      if (do_pop) void'(sb.pop_front());
      if (do_push) begin
        sb.push_back({mpc, 32'h1000_0000 | mpc});
        mpc = mpc + 32'd4;
      end
    end
    @(negedge clk);
    fq.redirect_valid = 1'b0;
  endtask

  initial begin
    rst               = 1'b0;
    fq.out_ready      = 1'b0;
    fq.redirect_valid = 1'b0;
    fq.redirect_pc    = '0;
    mpc               = 32'h0;
    #1;
    chk_state("reset");
    chk("reset_pc", 64'(fq.out_pc), 64'h0);
    chk("reset_instr", 64'(fq.out_instr), 64'h0);
    @(negedge clk);
    rst = 1'b1;

    // 1: streaming with decode always ready
    for (int i = 0; i < 6; i++) begin
      step(1'b1, 1'b0, 32'h0, "t1");
      chk("t1_pc", 64'(fq.out_pc), 64'(4 * i));
      chk("t1_cnt_le1", 64'(fq.count <= 1), 64'h1);
    end

    // 2: fresh reset, decode stalled until the queue fills
    rst = 1'b0;
    sb.delete();
    mpc = 32'h0;
    fq.out_ready = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 32'h0, "t2");
    chk("t2_count", 64'(fq.count), 64'd4);
    chk("t2_addr", 64'(fq.imem_addr), 64'h10);
    chk("t2_head", {fq.out_pc, fq.out_instr}, 64'h0000_0000_1000_0000);

    // 3: full, one pop with a simultaneous push
    step(1'b1, 1'b0, 32'h0, "t3");
    chk("t3_count", 64'(fq.count), 64'd4);
    chk("t3_addr", 64'(fq.imem_addr), 64'h14);
    chk("t3_pc", 64'(fq.out_pc), 64'h4);

    // 4: redirect while full and ready, unaligned target
    step(1'b1, 1'b1, 32'h0000_0103, "t4");
    chk("t4_count", 64'(fq.count), 64'd0);
    chk("t4_valid", 64'(fq.out_valid), 64'd0);
    chk("t4_addr", 64'(fq.imem_addr), 64'h100);
    step(1'b1, 1'b0, 32'h0, "t4b");
    chk("t4_pc", 64'(fq.out_pc), 64'h100);
    chk("t4_vld", 64'(fq.out_valid), 64'd1);

    // back-to-back redirects: the last one wins
    step(1'b1, 1'b1, 32'h0000_0200, "bb1");
    step(1'b1, 1'b1, 32'h0000_0300, "bb2");
    chk("bb_addr", 64'(fq.imem_addr), 64'h300);
    step(1'b1, 1'b0, 32'h0, "bb3");
    chk("bb_pc", 64'(fq.out_pc), 64'h300);

    // 5: PC wrap at the top of the address space
    step(1'b1, 1'b1, 32'hFFFF_FFFC, "t5");
    step(1'b1, 1'b0, 32'h0, "t5a");
    chk("t5_pc0", 64'(fq.out_pc), 64'hFFFF_FFFC);
    step(1'b1, 1'b0, 32'h0, "t5b");
    chk("t5_pc1", 64'(fq.out_pc), 64'h0);
    chk("t5_instr1", 64'(fq.out_instr), 64'h1000_0000);

    // 6: asynchronous reset between edges with three entries queued
    step(1'b0, 1'b1, 32'h0000_0040, "t6r");
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 32'h0, "t6");
    chk("t6_count3", 64'(fq.count), 64'd3);
    #2;
    rst = 1'b0;
    #1;
    chk("t6_valid_async", 64'(fq.out_valid), 64'd0);
    chk("t6_count_async", 64'(fq.count), 64'd0);
    sb.delete();
    mpc = 32'h0;
    @(negedge clk);
    rst = 1'b1;
    chk("t6_addr", 64'(fq.imem_addr), 64'h0);
    step(1'b1, 1'b0, 32'h0, "t6a");
    step(1'b1, 1'b0, 32'h0, "t6b");
    chk_state("final");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
